universal_shift_reg: RTL and testbench
======================================

# universal_shift_reg

Parametrised WIDTH-bit universal shift register, successor to the fixed 4-bit shifting register in the gate-library design. It supports hold, serial shift, rotate, parallel load and arithmetic shift in both directions, with a registered serial output. It sits alongside the gate primitives as the behavioural reference the gate-level register is checked against. An optional toggle counter replaces the ad-hoc per-gate power counters.

## Interface
- WIDTH, 4, register width in bits; legal range WIDTH >= 2
- CNT_WIDTH, 16, width of the toggle counter PWR_CNT
- CLK  input  1  clock; all state updates on the rising edge
- RST  input  1  synchronous, active-high reset
- ENB  input  1  enable; 0 = hold all state
- DIR  input  1  direction; 0 = left (toward MSB), 1 = right (toward LSB)
- MODO  input  2  mode: 00 shift, 01 rotate, 10 parallel load, 11 arithmetic shift
- S_IN  input  1  serial data in, used in mode 00 only
- D  input  WIDTH  parallel load data
- Q  output  WIDTH  register contents, registered
- S_OUT  output  1  bit shifted or rotated out on the last active edge, registered
- PWR_CNT  output  CNT_WIDTH  saturating count of Q bit toggles (see Configuration)

## Operation
- Reset: RST=1 at a rising edge forces Q=0, S_OUT=0, PWR_CNT=0. Reset overrides ENB and MODO.
- ENB=0, RST=0: Q, S_OUT and PWR_CNT hold.
- ENB=1, MODO=00, DIR=0: Q <= {Q[WIDTH-2:0], S_IN}; S_OUT <= Q[WIDTH-1].
- ENB=1, MODO=00, DIR=1: Q <= {S_IN, Q[WIDTH-1:1]}; S_OUT <= Q[0].
- ENB=1, MODO=01, DIR=0: Q <= {Q[WIDTH-2:0], Q[WIDTH-1]}; S_OUT <= Q[WIDTH-1].
- ENB=1, MODO=01, DIR=1: Q <= {Q[0], Q[WIDTH-1:1]}; S_OUT <= Q[0].
- ENB=1, MODO=10: Q <= D; S_OUT <= 0. DIR is ignored.
- ENB=1, MODO=11, DIR=0: Q <= {Q[WIDTH-2:0], 1'b0}; S_OUT <= Q[WIDTH-1].
- ENB=1, MODO=11, DIR=1: Q <= {Q[WIDTH-1], Q[WIDTH-1:1]}, i.e. sign-extended; S_OUT <= Q[0].
- S_IN is ignored in every mode other than 00.
- No X propagation from unused inputs. Every mode/DIR combination is defined.

## Timing
- Single-cycle latency: inputs sampled at edge k appear on Q and S_OUT after edge k.
- Q and S_OUT are purely registered; there is no combinational input-to-output path.
- Reset asserted mid-sequence takes effect at the next edge. The first operation after RST deasserts acts on Q=0.
- Back-to-back mode changes are allowed every cycle. No handshake or busy state.
- Rotate: WIDTH consecutive rotate edges return Q to its original value. S_OUT then shows the last bit rotated.

## Configuration
- Macro: SHIFT_REG_PWR_COUNT_EN.
- Defined:
  - PWR_CNT increments at each non-reset rising edge by popcount(Q_next ^ Q).
  - The sum saturates at 2^CNT_WIDTH-1 and never wraps.
  - Hold cycles add 0.
- Not defined: PWR_CNT is tied to 0 and no counter logic is synthesised. The port list is unchanged.

## Test plan
- Reset and load (WIDTH=4): RST=1 for 1 cycle -> Q=0000, S_OUT=0, PWR_CNT=0. Then MODO=10, D=1011, ENB=1 -> Q=1011, S_OUT=0.
- Shift-left sequence: Q=1011, MODO=00, DIR=0, S_IN=0,1,1 over 3 edges -> Q=0110, 1101, 1011; S_OUT=1, 0, 1.
- Rotate right wrap: Q=1000, MODO=01, DIR=1, 4 edges -> Q=0100, 0010, 0001, 1000; S_OUT=0, 0, 0, 1.
- Arithmetic shifts:
  - Q=1000, MODO=11, DIR=1 -> Q=1100, S_OUT=0.
  - Then DIR=0 -> Q=1000, S_OUT=1.
- Enable and reset priority:
  - ENB=0 with MODO=10, D=1111 -> Q unchanged.
  - RST=1 with ENB=1, MODO=10 -> Q=0000.
- Toggle count (macro defined, CNT_WIDTH=4): load 0000 -> 1111 gives PWR_CNT=4. Load 0000 gives 8. Load 1111 gives 12. Load 0000 gives 15 (saturated). Further toggles hold 15.
- Toggle count (macro undefined): same sequence -> PWR_CNT stays 0.

Source files
------------

// File: rtl/universal_shift_reg.sv
// universal_shift_reg
// WIDTH-bit universal shift register: hold, serial shift, rotate, parallel
// load and arithmetic shift in both directions, with a registered serial out.
// Optional feature macro: SHIFT_REG_PWR_COUNT_EN
//   defined   -> PWR_CNT is a saturating count of Q bit toggles
//   undefined -> PWR_CNT is tied to 0 and no counter logic exists
module universal_shift_reg #(
  parameter int WIDTH     = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 ENB,
  input  logic                 DIR,
  input  logic [1:0]           MODO,
  input  logic                 S_IN,
  input  logic [WIDTH-1:0]     D,
  output logic [WIDTH-1:0]     Q,
  output logic                 S_OUT,
  output logic [CNT_WIDTH-1:0] PWR_CNT
);

  typedef enum logic [1:0] {
    MODE_SHIFT  = 2'b00,
    MODE_ROTATE = 2'b01,
    MODE_LOAD   = 2'b10,
    MODE_ARITH  = 2'b11
  } mode_e;

  logic [WIDTH-1:0] q_d, q_q;
  logic             s_out_d, s_out_q;

  // Next register contents and serial-out bit for the selected mode/direction
  always_comb begin
    // NOTE: hold values are assigned first so every path drives q_d/s_out_d
    // and no latch is inferred when ENB is low.
    q_d     = q_q;
    s_out_d = s_out_q;
    if (ENB) begin
      case (mode_e'(MODO))
        MODE_SHIFT: begin
          if (DIR) begin
            q_d     = {S_IN, q_q[WIDTH-1:1]};
            s_out_d = q_q[0];
          end else begin
            q_d     = {q_q[WIDTH-2:0], S_IN};
            s_out_d = q_q[WIDTH-1];
          end
        end
        MODE_ROTATE: begin
          if (DIR) begin
            q_d     = {q_q[0], q_q[WIDTH-1:1]};
            s_out_d = q_q[0];
          end else begin
            q_d     = {q_q[WIDTH-2:0], q_q[WIDTH-1]};
            s_out_d = q_q[WIDTH-1];
          end
        end
        MODE_LOAD: begin
          q_d     = D;
          s_out_d = 1'b0;
        end
        MODE_ARITH: begin
          if (DIR) begin
            // Sign-extending right shift
            q_d     = {q_q[WIDTH-1], q_q[WIDTH-1:1]};
            s_out_d = q_q[0];
          end else begin
            q_d     = {q_q[WIDTH-2:0], 1'b0};
            s_out_d = q_q[WIDTH-1];
          end
        end
      endcase
    end
  end

  // Register state; synchronous reset overrides enable and mode
  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its neighbours.
    if (RST) begin
      q_q     <= '0;
      s_out_q <= 1'b0;
    end else begin
      q_q     <= q_d;
      s_out_q <= s_out_d;
    end
  end

  assign Q     = q_q;
  assign S_OUT = s_out_q;

`ifdef SHIFT_REG_PWR_COUNT_EN
  localparam int TOG_W = $clog2(WIDTH + 1);
  localparam int SUM_W = ((CNT_WIDTH > TOG_W) ? CNT_WIDTH : TOG_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_WIDTH{1'b1}});

  logic [TOG_W-1:0]     toggles;
  logic [SUM_W-1:0]     cnt_sum;
  logic [CNT_WIDTH-1:0] pwr_cnt_d, pwr_cnt_q;

  // Saturating accumulate of the number of Q bits that change this edge;
  // holds add nothing because q_d equals q_q
  always_comb begin
    toggles = '0;
    for (int i = 0; i < WIDTH; i++) begin
      toggles = toggles + TOG_W'(q_d[i] ^ q_q[i]);
    end
    cnt_sum   = SUM_W'(pwr_cnt_q) + SUM_W'(toggles);
    pwr_cnt_d = (cnt_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
  end

  // Toggle counter register, cleared with the shift register
  always_ff @(posedge CLK) begin
    if (RST) pwr_cnt_q <= '0;
    else     pwr_cnt_q <= pwr_cnt_d;
  end

  assign PWR_CNT = pwr_cnt_q;
`else
  assign PWR_CNT = '0;
`endif

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg: directed sequences with
// literal expectations on a 4-bit instance, then randomized stimulus on a
// 4-bit and an 8-bit instance against an arithmetic reference model.
module tb_universal_shift_reg;

`ifdef SHIFT_REG_PWR_COUNT_EN
  localparam bit PWR_EN = 1'b1;
`else
  localparam bit PWR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, enb, dir, s_in;
  logic [1:0] modo;
  logic [3:0] d4;
  logic [7:0] d8;
  logic [3:0] q4;
  logic [7:0] q8;
  logic       s_out4, s_out8;
  logic [3:0] cnt4;
  logic [15:0] cnt8;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  longint m4_q, m4_c, m8_q, m8_c;
  bit     m4_s, m8_s;

  always #5 clk = ~clk;

  universal_shift_reg #(.WIDTH(4), .CNT_WIDTH(4)) dut4 (
    .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .MODO(modo), .S_IN(s_in),
    .D(d4), .Q(q4), .S_OUT(s_out4), .PWR_CNT(cnt4)
  );

  universal_shift_reg #(.WIDTH(8), .CNT_WIDTH(16)) dut8 (
    .CLK(clk), .RST(rst), .ENB(enb), .DIR(dir), .MODO(modo), .S_IN(s_in),
    .D(d8), .Q(q8), .S_OUT(s_out8), .PWR_CNT(cnt8)
  );

  task automatic check(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Behavioural model: operations expressed as integer arithmetic on the value
  task automatic model_step(input int w, input int cw, input bit r, input bit e,
                            input bit dr, input bit [1:0] md, input bit si,
                            input longint dv, inout longint q, inout bit s,
                            inout longint c);
    longint mask, nq, sv, diff;
    bit     msb, lsb, ns;
    int     pc;
    mask = (longint'(1) << w) - 1;
    msb  = ((q >> (w - 1)) & 1) != 0;
    lsb  = (q & 1) != 0;
    nq   = q;
    ns   = s;
    if (r) begin
      q = 0; s = 0; c = 0;
      return;
    end
    if (e) begin
      case (md)
        2'd0: if (dr) begin nq = (q >> 1) + (longint'(si) << (w - 1)); ns = lsb; end
              else    begin nq = (q * 2 + si) & mask;                  ns = msb; end
        2'd1: if (dr) begin nq = (q >> 1) + (longint'(lsb) << (w - 1)); ns = lsb; end
              else    begin nq = (q * 2 + msb) & mask;                  ns = msb; end
        2'd2: begin nq = dv; ns = 0; end
        default: if (dr) begin
                   sv = msb ? q - (longint'(1) << w) : q;
                   nq = (sv >>> 1) & mask; ns = lsb;
                 end else begin
                   nq = (q * 2) & mask; ns = msb;
                 end
      endcase
    end
    diff = nq ^ q;
    pc = 0;
    for (int i = 0; i < w; i++) if (((diff >> i) & 1) != 0) pc++;
    if (PWR_EN) begin
      c = c + pc;
      if (c > (longint'(1) << cw) - 1) c = (longint'(1) << cw) - 1;
    end else begin
      c = 0;
    end
    q = nq;
    s = ns;
  endtask

  // Drive one cycle on both instances, advance models, compare everything
  task automatic apply(input bit r, input bit e, input bit dr, input bit [1:0] md,
                       input bit si, input logic [3:0] dv4, input logic [7:0] dv8);
    rst = r; enb = e; dir = dr; modo = md; s_in = si; d4 = dv4; d8 = dv8;
    @(posedge clk);
    model_step(4, 4,  r, e, dr, md, si, longint'(dv4), m4_q, m4_s, m4_c);
    model_step(8, 16, r, e, dr, md, si, longint'(dv8), m8_q, m8_s, m8_c);
    #1;
    check("q4",     longint'(q4),     m4_q);
    check("s_out4", longint'(s_out4), longint'(m4_s));
    check("cnt4",   longint'(cnt4),   m4_c);
    check("q8",     longint'(q8),     m8_q);
    check("s_out8", longint'(s_out8), longint'(m8_s));
    check("cnt8",   longint'(cnt8),   m8_c);
  endtask

  initial begin
    logic [3:0] shl_exp [3];
    logic       shl_sout[3];
    logic [3:0] ror_exp [4];
    logic       ror_sout[4];
    logic [3:0] tog_d   [5];
    int         tog_cnt [5];
    shl_exp = '{4'b0110, 4'b1101, 4'b1011};
    shl_sout = '{1'b1, 1'b0, 1'b1};
    ror_exp = '{4'b0100, 4'b0010, 4'b0001, 4'b1000};
    ror_sout = '{1'b0, 1'b0, 1'b0, 1'b1};
    tog_d   = '{4'b1111, 4'b0000, 4'b1111, 4'b0000, 4'b1111};
    tog_cnt = '{4, 8, 12, 15, 15};

    m4_q = 0; m4_c = 0; m4_s = 0; m8_q = 0; m8_c = 0; m8_s = 0;
    rst = 1; enb = 0; dir = 0; modo = 0; s_in = 0; d4 = 0; d8 = 0;

    // Reset and load
    apply(1, 0, 0, 2'b00, 0, 4'h0, 8'h00);
    check("rst_q", longint'(q4), 0);
    check("rst_s", longint'(s_out4), 0);
    check("rst_cnt", longint'(cnt4), 0);
    apply(0, 1, 1, 2'b10, 1, 4'b1011, 8'hA5);
    check("load_q", longint'(q4), longint'(4'b1011));
    check("load_s", longint'(s_out4), 0);

    // Shift-left sequence with S_IN = 0,1,1
    for (int i = 0; i < 3; i++) begin
      apply(0, 1, 0, 2'b00, (i != 0), 4'h0, 8'h00);
      check("shl_q", longint'(q4), longint'(shl_exp[i]));
      check("shl_s", longint'(s_out4), longint'(shl_sout[i]));
    end

    // Rotate right wraps after WIDTH edges
    apply(0, 1, 0, 2'b10, 0, 4'b1000, 8'h81);
    for (int i = 0; i < 4; i++) begin
      apply(0, 1, 1, 2'b01, 1, 4'h0, 8'h00);
      check("ror_q", longint'(q4), longint'(ror_exp[i]));
      check("ror_s", longint'(s_out4), longint'(ror_sout[i]));
    end

    // Arithmetic shifts
    apply(0, 1, 1, 2'b11, 1, 4'h0, 8'h00);
    check("asr_q", longint'(q4), longint'(4'b1100));
    check("asr_s", longint'(s_out4), 0);
    apply(0, 1, 0, 2'b11, 1, 4'h0, 8'h00);
    check("asl_q", longint'(q4), longint'(4'b1000));
    check("asl_s", longint'(s_out4), 1);

    // Enable and reset priority
    apply(0, 0, 0, 2'b10, 0, 4'b1111, 8'hFF);
    check("hold_q", longint'(q4), longint'(4'b1000));
    apply(1, 1, 0, 2'b10, 0, 4'b1111, 8'hFF);
    check("rst_prio_q", longint'(q4), 0);

    // Toggle count and saturation
    for (int i = 0; i < 5; i++) begin
      apply(0, 1, 0, 2'b10, 0, tog_d[i], 8'h00);
      check("tog_cnt", longint'(cnt4), PWR_EN ? longint'(tog_cnt[i]) : 0);
    end
    apply(0, 0, 0, 2'b10, 0, 4'h0, 8'h00);
    check("tog_hold", longint'(cnt4), PWR_EN ? 15 : 0);

    // Randomized traffic against the model
    apply(1, 0, 0, 2'b00, 0, 4'h0, 8'h00);
    for (int i = 0; i < 600; i++) begin
      apply(($urandom_range(0, 29) == 0), ($urandom_range(0, 5) != 0),
            1'($urandom), 2'($urandom), 1'($urandom),
            4'($urandom), 8'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Overall time bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
